// File: rtl/idt_cfg_ctrl.sv
// Serial configuration sequencer for an IDT clock synthesizer (sclk/data/strobe).
// Takes one 24-bit word per handshake, shifts it MSB-first, strobes, then waits for the PLL to settle.
module idt_cfg_ctrl #(
  parameter int          CLK_DIV    = 4,
  parameter int          STROBE_CYC = 8,
  parameter int          SETTLE_CYC = 1024,
  parameter bit          AUTO_START = 1'b1,
  parameter logic [23:0] INIT_CFG   = 24'h2B0404
) (
  input  logic        osc_clk,
  input  logic        osc_reset,
  input  logic        cfg_valid,
  input  logic [23:0] cfg_word,
  output logic        cfg_ready,
  output logic        busy,
  output logic        done,
  output logic        locked,
  output logic        idt_sclk,
  output logic        idt_data,
  output logic        idt_strobe
);

  localparam int HALF_W = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int STB_W  = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STROBE_CYC - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STROBE,
    SETTLE
  } state_t;

  state_t              state;
  logic                auto_pend;
  // Bit 23 goes straight to idt_data on accept; only the remaining 23 bits are held.
  logic [22:0]         shreg;
  logic [4:0]          bit_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic                phase;
  logic [STB_W-1:0]    stb_cnt;
  logic [SET_W-1:0]    set_cnt;

  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      state      <= IDLE;
      auto_pend  <= AUTO_START;
      shreg      <= '0;
      bit_cnt    <= '0;
      half_cnt   <= '0;
      phase      <= 1'b0;
      stb_cnt    <= '0;
      set_cnt    <= '0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      idt_sclk   <= 1'b0;
      idt_data   <= 1'b0;
      idt_strobe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The power-up word takes the place of a handshake on the first cycle out of reset.
          if (auto_pend || (cfg_valid && cfg_ready)) begin
            auto_pend <= 1'b0;
            state     <= SHIFT;
            shreg     <= auto_pend ? INIT_CFG[22:0] : cfg_word[22:0];
            idt_data  <= auto_pend ? INIT_CFG[23]   : cfg_word[23];
            idt_sclk  <= 1'b0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            locked    <= 1'b0;
          end else begin
            cfg_ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!phase) begin
              phase    <= 1'b1;
              idt_sclk <= 1'b1;
            end else if (bit_cnt == 5'd23) begin
              state      <= STROBE;
              stb_cnt    <= '0;
              idt_sclk   <= 1'b0;
              idt_data   <= 1'b0;
              idt_strobe <= 1'b1;
            end else begin
              phase    <= 1'b0;
              bit_cnt  <= bit_cnt + 5'd1;
              idt_sclk <= 1'b0;
              idt_data <= shreg[22];
              shreg    <= {shreg[21:0], 1'b0};
            end
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end

        STROBE: begin
          if (stb_cnt == STB_LAST) begin
            state      <= SETTLE;
            set_cnt    <= '0;
            idt_strobe <= 1'b0;
          end else begin
            stb_cnt <= stb_cnt + STB_W'(1);
          end
        end

        SETTLE: begin
          if (set_cnt == SET_LAST) begin
            state     <= IDLE;
            done      <= 1'b1;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            set_cnt <= set_cnt + SET_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idt_cfg_ctrl.sv
// Three controller instances with different timing, checked every cycle against a
// closed-form timeline model (outputs as a function of cycles since accept).
module tb_idt_cfg_ctrl;

  localparam int          NI        = 3;
  localparam int          DIV [NI]  = '{4, 1, 3};
  localparam int          STB [NI]  = '{8, 1, 5};
  localparam int          SET [NI]  = '{1024, 1, 20};
  localparam bit          AUTO [NI] = '{1'b1, 1'b0, 1'b0};
  localparam logic [23:0] INIT      = 24'h2B0404;
  localparam int          LIMIT     = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NI-1:0] valid;
  logic [23:0]   word [NI];
  logic [NI-1:0] rdy, bsy, dn, lck, sck, dat, stb;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      idt_cfg_ctrl #(
        .CLK_DIV   (DIV[gi]),
        .STROBE_CYC(STB[gi]),
        .SETTLE_CYC(SET[gi]),
        .AUTO_START(AUTO[gi]),
        .INIT_CFG  (INIT)
      ) dut (
        .osc_clk   (clk),
        .osc_reset (rst),
        .cfg_valid (valid[gi]),
        .cfg_word  (word[gi]),
        .cfg_ready (rdy[gi]),
        .busy      (bsy[gi]),
        .done      (dn[gi]),
        .locked    (lck[gi]),
        .idt_sclk  (sck[gi]),
        .idt_data  (dat[gi]),
        .idt_strobe(stb[gi])
      );
    end
  endgenerate

  int checks = 0;
  int failures = 0;

  // Model state
  bit          rstp;
  bit          m_active [NI];
  int          m_t0 [NI];
  logic [23:0] m_w [NI];
  bit          m_lock [NI];
  int          seqs [NI];
  int          m_dones [NI];
  // Pin monitor and requester state
  int          rises [NI];
  logic [23:0] cap [NI];
  logic        psck [NI];
  logic        pstb [NI];
  bit          acc [NI];
  int          gap [NI];
  int          widx [NI];
  int          r2;

  task automatic check(input string name, input int i, input int n,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, i, n, act, exp);
    end
  endtask

  function automatic logic [23:0] next_word(input int i, input int k);
    logic [23:0] w;
    w = 24'($urandom);
    if (i == 2) begin
      case (k)
        0: w = 24'hA5C3F0;
        1: w = 24'h000001;
        2: w = 24'hFFFFFF;
        3: w = 24'h000000;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic drive(input int n);
    bit en;
    if (r2 < 0 && m_active[0] && seqs[0] == 2 && (n - m_t0[0]) == 81) r2 = n;
    rst = (n < 5) || (r2 >= 0 && n >= r2 && n < r2 + 2);
    for (int i = 0; i < NI; i++) begin
      en = (i == 0) ? (m_dones[0] >= 1 && seqs[0] < 2) : 1'b1;
      if (acc[i]) begin
        acc[i]   = 1'b0;
        valid[i] = 1'b0;
        if (i == 2 && widx[i] < 4) gap[i] = 0;
        else if (i == 1)           gap[i] = $urandom_range(0, 3);
        else                       gap[i] = $urandom_range(0, 30);
      end
      if (!valid[i]) begin
        word[i] = 24'($urandom);
        if (en) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            valid[i] = 1'b1;
            word[i]  = next_word(i, widx[i]);
            widx[i]++;
          end
        end
      end
    end
  endtask

  task automatic compare_and_update(input int n);
    logic [6:0] e;
    int rel, sh, endc, k;
    for (int i = 0; i < NI; i++) begin
      sh   = 48 * DIV[i];
      endc = sh + STB[i] + SET[i] + 1;
      rel  = n - m_t0[i];
      // {ready, busy, done, locked, sclk, data, strobe}
      e = 7'b0;
      if (rstp) e = 7'b0;
      else if (m_active[i]) begin
        if (rel <= sh) begin
          k = (rel - 1) / (2 * DIV[i]);
          e = {1'b0, 1'b1, 1'b0, 1'b0, (((rel - 1) % (2 * DIV[i])) >= DIV[i]), m_w[i][23 - k], 1'b0};
        end else if (rel <= sh + STB[i]) e = 7'b0100001;
        else if (rel < endc)             e = 7'b0100000;
        else                             e = 7'b1011000;
      end else begin
        e = {1'b1, 1'b0, 1'b0, m_lock[i], 3'b000};
      end
      check("outputs", i, n, {25'b0, rdy[i], bsy[i], dn[i], lck[i], sck[i], dat[i], stb[i]}, {25'b0, e});

      if (rstp) rises[i] = 0;
      if (sck[i] && !psck[i]) begin
        cap[i] = {cap[i][22:0], dat[i]};
        rises[i]++;
      end
      if (stb[i] && !pstb[i]) begin
        check("sclk_rises", i, n, rises[i], 24);
        check("captured_word", i, n, cap[i], m_w[i]);
        if (i == 0) check("strobe_start_193", i, n, rel, 193);
        if (i == 2 && seqs[2] == 1) check("word_a5c3f0", i, n, cap[i], 24'hA5C3F0);
        rises[i] = 0;
      end
      if (dn[i]) check("done_rel", i, n, rel, (i == 0) ? 1225 : (i == 1) ? 51 : 170);
      psck[i] = sck[i];
      pstb[i] = stb[i];

      if (m_active[i] && rel == endc) begin
        m_active[i] = 1'b0;
        m_lock[i]   = 1'b1;
        m_dones[i]++;
      end
      if (rst) begin
        m_active[i] = 1'b0;
        m_lock[i]   = 1'b0;
        acc[i]      = 1'b0;
      end else if (!m_active[i]) begin
        if (rstp && AUTO[i]) begin
          m_active[i] = 1'b1; m_t0[i] = n; m_w[i] = INIT; m_lock[i] = 1'b0; seqs[i]++;
        end else if (!rstp && valid[i]) begin
          m_active[i] = 1'b1; m_t0[i] = n; m_w[i] = word[i]; m_lock[i] = 1'b0; seqs[i]++;
          acc[i] = 1'b1;
        end
      end
    end
    rstp = rst;
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    valid = '0;
    rstp  = 1'b1;
    r2    = -1;
    for (int i = 0; i < NI; i++) begin
      word[i] = '0; m_active[i] = 1'b0; m_t0[i] = 0; m_w[i] = '0; m_lock[i] = 1'b0;
      seqs[i] = 0; m_dones[i] = 0; rises[i] = 0; cap[i] = '0; psck[i] = 1'b0;
      pstb[i] = 1'b0; acc[i] = 1'b0; gap[i] = 0; widx[i] = 0;
    end
    n = 0;
    while (n < LIMIT && !(r2 >= 0 && m_dones[0] >= 2)) begin
      @(posedge clk);
      #2;
      drive(n);
      @(negedge clk);
      compare_and_update(n);
      n++;
    end
    check("auto_restart_completed", 0, n, {31'b0, (r2 >= 0 && m_dones[0] >= 2)}, 32'd1);
    check("inst2_seq_count_min4", 2, n, {31'b0, (seqs[2] >= 4)}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
